kalu_issue: RTL

- Issue/writeback stage directly upstream of K_ALU8.
- Accepts packed instructions through a valid/ready handshake and buffers them in a small FIFO. Reads operands from an 8x8 register bank and builds the 32-bit ALU command word (func[31:28], A[15:8], B[7:0]). Captures the ALU's 8-bit result one cycle later and writes it back to the destination register.
- Turns the combinational K_ALU8 into a sequenced, register-to-register datapath.

---
 rtl/kalu_issue.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/kalu_issue.sv
// kalu_issue: instruction FIFO, 8x8 register bank and IDLE/EXEC/WB sequencer that
// drives the combinational K_ALU8 with a registered command and writes its result back.
module kalu_issue #(
    parameter int FIFO_DEPTH = 4,
    parameter int NREG       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [19:0] in_instr,
    output logic [31:0] command,
    input  logic [7:0]  alu_res,
    output logic        wb_valid,
    output logic [2:0]  wb_rd,
    output logic [7:0]  wb_data,
    output logic        busy,
    input  logic [2:0]  dbg_addr,
    output logic [7:0]  dbg_data
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ZERO = (PW+1)'(0);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    // Queue entries drop the always-zero bits [11:8]:
    // [15] li, [14:11] func, [10:8] rd, [7:0] imm or {0,rs,0,rt}.
    logic [15:0]   fifo_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   count_r;
    logic [7:0]    regs_r [NREG];
    state_t        state_r;
    state_t        state_s;
    logic [31:0]   command_r;
    logic          wb_valid_r;
    logic [2:0]    wb_rd_r;
    logic [7:0]    wb_data_r;

    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic          load_s;
    logic          have_next_s;
    logic [15:0]   in_entry_s;
    logic [15:0]   head_s;
    logic [15:0]   next_s;
    logic [15:0]   src_s;
    logic [7:0]    opa_s;
    logic [7:0]    opb_s;
    logic [31:0]   cmd_s;
    logic          unused_s;

    function automatic logic [31:0] build_cmd(input logic       li,
                                              input logic [3:0] func,
                                              input logic [7:0] a,
                                              input logic [7:0] b);
        if (li) begin
            build_cmd = {func, 28'h0000000};
        end else begin
            build_cmd = {func, 12'h000, a, b};
        end
    endfunction

    assign in_entry_s  = {in_instr[19:12], in_instr[7:0]};
    assign full_s      = (count_r == CNT_FULL);
    assign push_s      = in_valid && !full_s;
    assign head_s      = fifo_r[rd_ptr_r];
    // With only the retiring entry left, the follower can only be the word arriving now.
    assign next_s      = (count_r > CNT_ONE) ? fifo_r[rd_ptr_r + PTR_ONE] : in_entry_s;
    assign have_next_s = (count_r > CNT_ONE) || push_s;
    assign unused_s    = ^{in_instr[11:8], src_s[10:7], src_s[3]};

    assign in_ready = !full_s;
    assign busy     = (state_r != IDLE) || (count_r != CNT_ZERO);
    assign command  = command_r;
    assign wb_valid = wb_valid_r;
    assign wb_rd    = wb_rd_r;
    assign wb_data  = wb_data_r;
    assign dbg_data = regs_r[dbg_addr];

    // Sequencer next state, command load and FIFO pop decisions.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        pop_s   = 1'b0;
        src_s   = head_s;
        case (state_r)
            IDLE: begin
                if (count_r != CNT_ZERO) begin
                    load_s  = 1'b1;
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                state_s = WB;
            end
            WB: begin
                pop_s = 1'b1;
                if (have_next_s) begin
                    load_s  = 1'b1;
                    src_s   = next_s;
                    state_s = EXEC;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand fetch; in WB the bank write lands at the same edge, so forward it.
    always_comb begin
        if ((state_r == WB) && (src_s[6:4] == wb_rd_r)) begin
            opa_s = wb_data_r;
        end else begin
            opa_s = regs_r[src_s[6:4]];
        end
        if ((state_r == WB) && (src_s[2:0] == wb_rd_r)) begin
            opb_s = wb_data_r;
        end else begin
            opb_s = regs_r[src_s[2:0]];
        end
        cmd_s = build_cmd(src_s[15], src_s[14:11], opa_s, opb_s);
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; stale contents are never read because occupancy gates every access.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_r[wr_ptr_r] <= in_entry_s;
        end
    end

    // Register bank, written once per retired instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 8'h00;
            end
        end else if (state_r == WB) begin
            regs_r[wb_rd_r] <= wb_data_r;
        end
    end

    // Command word to the ALU; holds until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            command_r <= 32'h0000_0000;
        end else if (load_s) begin
            command_r <= cmd_s;
        end
    end

    // Result capture at the end of EXEC, presented during WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_r <= 1'b0;
            wb_rd_r    <= 3'd0;
            wb_data_r  <= 8'h00;
        end else if (state_r == EXEC) begin
            wb_valid_r <= 1'b1;
            wb_rd_r    <= head_s[10:8];
            wb_data_r  <= head_s[15] ? head_s[7:0] : alu_res;
        end else begin
            wb_valid_r <= 1'b0;
        end
    end

endmodule
